// File: rtl/exc_pkg.sv
// Shared types and constants for the vectored exception controller:
// FSM state encoding, MRS read-select codes and the default vector base.
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HANDLER = 2'b01,
        HALT    = 2'b10
    } exc_state_e;

    localparam logic [1:0] SEL_ELR  = 2'b00;
    localparam logic [1:0] SEL_ESR  = 2'b01;
    localparam logic [1:0] SEL_ERR  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam logic [63:0] DEFAULT_VEC_BASE = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: index 0 wins. Produces a one-hot grant,
// the binary index of the winner and a valid flag.
module prio_enc #(
    parameter int NSRC  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NSRC-1:0]  req,
    output logic [NSRC-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Isolate the lowest set bit, then fold the one-hot grant into an index.
    always_comb begin
        grant = req & (~req + {{(NSRC-1){1'b0}}, 1'b1});
        valid = |req;
        idx   = '0;
        for (int i = 0; i < NSRC; i++) begin
            idx = idx | ({IDX_W{grant[i]}} & IDX_W'(i));
        end
    end

endmodule

// File: rtl/exc_ctrl_vec.sv
// Vectored exception controller: fixed-priority arbitration with pending
// queue, ELR/ESR/ERR capture, fetch redirect, ERET service and double-fault trap.
module exc_ctrl_vec
    import exc_pkg::*;
#(
    parameter int             N          = 64,
    parameter int             NSRC       = 4,
    parameter int             ESR_W      = 4,
    parameter logic [N-1:0]   VEC_BASE   = N'(DEFAULT_VEC_BASE),
    parameter logic [N-1:0]   VEC_STRIDE = '0,
    parameter logic [NSRC-1:0] SYNC_MASK = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] exc_req,
    input  logic            ERet,
    input  logic [N-1:0]    NextPC,
    input  logic [N-1:0]    imem_addr,
    input  logic [N-1:0]    ALUBranch,
    input  logic [1:0]      EDataSel,
    output logic            EProc,
    output logic [N-1:0]    EVAddr,
    output logic [N-1:0]    PCBranch,
    output logic [N-1:0]    readData,
    output logic            ExcAck,
    output logic            exc_busy,
    output logic            eret_err,
    output logic            dbl_fault
);

    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    exc_state_e        state_r;
    exc_state_e        state_next_s;
    logic [NSRC-1:0]   pending_r;
    logic [N-1:0]      elr_r;
    logic [N-1:0]      err_r;
    logic [ESR_W-1:0]  esr_r;
    logic              exc_ack_r;
    logic              eret_err_r;
    logic              dbl_fault_r;

    logic [NSRC-1:0]   req_eff_s;
    logic [NSRC-1:0]   grant_s;
    logic [IDX_W-1:0]  idx_s;
    logic              valid_s;
    logic              take_s;
    logic              halt_s;
    logic              eret_done_s;
    logic              eret_bad_s;
    logic [NSRC-1:0]   taken_s;
    logic [ESR_W-1:0]  esr_code_s;
    logic [N-1:0]      vec_addr_s;

    assign req_eff_s = pending_r | exc_req;

    prio_enc #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (req_eff_s),
        .grant (grant_s),
        .idx   (idx_s),
        .valid (valid_s)
    );

    // Next-state and control decode; pending requests are only taken from IDLE.
    always_comb begin
        state_next_s = state_r;
        take_s       = 1'b0;
        halt_s       = 1'b0;
        eret_done_s  = 1'b0;
        eret_bad_s   = 1'b0;
        taken_s      = '0;
        EProc        = 1'b0;
        case (state_r)
            IDLE: begin
                eret_bad_s = ERet;
                if (valid_s) begin
                    take_s       = 1'b1;
                    taken_s      = grant_s;
                    EProc        = 1'b1;
                    state_next_s = HANDLER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HANDLER: begin
                if (ERet) begin
                    eret_done_s  = 1'b1;
                    state_next_s = IDLE;
                end else if (|(exc_req & SYNC_MASK)) begin
                    halt_s       = 1'b1;
                    state_next_s = HALT;
                end else begin
                    state_next_s = HANDLER;
                end
            end
            HALT: begin
                EProc        = 1'b1;
                state_next_s = HALT;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign esr_code_s = ESR_W'(32'(idx_s) + 32'd1);
    assign vec_addr_s = VEC_BASE + (N'(idx_s) * VEC_STRIDE);

    // Fetch redirect target and branch mux; a trapped double fault always re-enters vector 0.
    always_comb begin
        if (state_r == HALT) begin
            EVAddr = VEC_BASE;
        end else begin
            EVAddr = vec_addr_s;
        end
        if (eret_done_s) begin
            PCBranch = elr_r;
        end else begin
            PCBranch = ALUBranch;
        end
    end

    // MRS read path.
    always_comb begin
        case (EDataSel)
            SEL_ELR:  readData = elr_r;
            SEL_ESR:  readData = N'(esr_r);
            SEL_ERR:  readData = err_r;
            SEL_ZERO: readData = '0;
            default:  readData = '0;
        endcase
    end

    // FSM state, pending queue and one-cycle acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            pending_r <= '0;
            exc_ack_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pending_r <= req_eff_s & ~taken_s;
            exc_ack_r <= take_s;
        end
    end

    // Exception context capture; ERR is refreshed on a double fault to record the culprit PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elr_r <= '0;
            esr_r <= '0;
            err_r <= '0;
        end else if (take_s) begin
            elr_r <= (|(grant_s & SYNC_MASK)) ? imem_addr : NextPC;
            esr_r <= esr_code_s;
            err_r <= imem_addr;
        end else if (halt_s) begin
            err_r <= imem_addr;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eret_err_r  <= 1'b0;
            dbl_fault_r <= 1'b0;
        end else begin
            eret_err_r  <= eret_err_r | eret_bad_s;
            dbl_fault_r <= dbl_fault_r | halt_s;
        end
    end

    assign ExcAck    = exc_ack_r;
    assign exc_busy  = (state_r != IDLE);
    assign eret_err  = eret_err_r;
    assign dbl_fault = dbl_fault_r;

endmodule

// File: tb/tb_exc_ctrl_vec.sv
// Self-checking bench for exc_ctrl_vec: directed scenarios plus randomized
// traffic compared against a behavioural model of the exception rules.
module tb_exc_ctrl_vec;

    logic        clk;
    logic        reset;
    logic [3:0]  exc_req;
    logic        ERet;
    logic [63:0] NextPC;
    logic [63:0] imem_addr;
    logic [63:0] ALUBranch;
    logic [1:0]  EDataSel;
    logic        EProc;
    logic [63:0] EVAddr;
    logic [63:0] PCBranch;
    logic [63:0] readData;
    logic        ExcAck;
    logic        exc_busy;
    logic        eret_err;
    logic        dbl_fault;

    int checks   = 0;
    int failures = 0;

    // model: 0 idle, 1 handler, 2 halt
    int          m_state;
    logic [3:0]  m_pend;
    logic [63:0] m_elr;
    logic [63:0] m_err;
    logic [3:0]  m_esr;
    logic        m_ack;
    logic        m_eerr;
    logic        m_dbl;

    localparam logic [3:0] MASK = 4'b0001;

    exc_ctrl_vec #(
        .N          (64),
        .NSRC       (4),
        .ESR_W      (4),
        .VEC_BASE   (64'hD8),
        .VEC_STRIDE (64'h10),
        .SYNC_MASK  (MASK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .exc_req   (exc_req),
        .ERet      (ERet),
        .NextPC    (NextPC),
        .imem_addr (imem_addr),
        .ALUBranch (ALUBranch),
        .EDataSel  (EDataSel),
        .EProc     (EProc),
        .EVAddr    (EVAddr),
        .PCBranch  (PCBranch),
        .readData  (readData),
        .ExcAck    (ExcAck),
        .exc_busy  (exc_busy),
        .eret_err  (eret_err),
        .dbl_fault (dbl_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; exc_req = 4'b0; ERet = 1'b0; EDataSel = 2'b00;
        #2;
        reset = 1'b0;
        m_state = 0; m_pend = 4'b0; m_elr = 64'h0; m_err = 64'h0; m_esr = 4'h0;
        m_ack = 1'b0; m_eerr = 1'b0; m_dbl = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (exc_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", exc_busy); end
        checks++; if (ExcAck !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ExcAck); end
        checks++; if (EProc !== 1'b0) begin failures++; $display("FAIL rst_eproc got=%b exp=0", EProc); end
        checks++; if (readData !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", readData); end
        checks++; if ({eret_err, dbl_fault} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {eret_err, dbl_fault}); end
    endtask

    task automatic test_vector_basic();
        logic [63:0] exp_rd [4];
        apply_reset();
        @(negedge clk);
        exc_req = 4'b0100; imem_addr = 64'h40; NextPC = 64'h44; ALUBranch = 64'h100;
        #1;
        checks++; if (EProc !== 1'b1) begin failures++; $display("FAIL vb_eproc got=%b exp=1", EProc); end
        checks++; if (EVAddr !== 64'hF8) begin failures++; $display("FAIL vb_evaddr got=%h exp=f8", EVAddr); end
        @(negedge clk);
        exc_req = 4'b0;
        #1;
        checks++; if (ExcAck !== 1'b1) begin failures++; $display("FAIL vb_ack got=%b exp=1", ExcAck); end
        checks++; if (EProc !== 1'b0) begin failures++; $display("FAIL vb_eproc_h got=%b exp=0", EProc); end
        exp_rd[0] = 64'h44; exp_rd[1] = 64'h3; exp_rd[2] = 64'h40; exp_rd[3] = 64'h0;
        for (int s = 0; s < 4; s++) begin
            EDataSel = 2'(s);
            #1;
            checks++; if (readData !== exp_rd[s]) begin failures++; $display("FAIL vb_rdata sel=%0d got=%h exp=%h", s, readData, exp_rd[s]); end
        end
        @(negedge clk);
        ERet = 1'b1;
        #1;
        checks++; if (ExcAck !== 1'b0) begin failures++; $display("FAIL vb_ack_pulse got=%b exp=0", ExcAck); end
        checks++; if (PCBranch !== 64'h44) begin failures++; $display("FAIL vb_eret_pcb got=%h exp=44", PCBranch); end
        @(negedge clk);
        ERet = 1'b0;
        #1;
        checks++; if (exc_busy !== 1'b0) begin failures++; $display("FAIL vb_idle got=%b exp=0", exc_busy); end
        checks++; if (eret_err !== 1'b0) begin failures++; $display("FAIL vb_eret_err got=%b exp=0", eret_err); end
    endtask

    task automatic test_pending();
        apply_reset();
        @(negedge clk);
        exc_req = 4'b0110; imem_addr = 64'h100; NextPC = 64'h104; ALUBranch = 64'h900;
        #1;
        checks++; if (EVAddr !== 64'hE8 || EProc !== 1'b1) begin failures++; $display("FAIL pd_first got=%h/%b exp=e8/1", EVAddr, EProc); end
        @(negedge clk);
        exc_req = 4'b0; ERet = 1'b1;
        #1;
        checks++; if (PCBranch !== 64'h104) begin failures++; $display("FAIL pd_eret got=%h exp=104", PCBranch); end
        checks++; if (EProc !== 1'b0) begin failures++; $display("FAIL pd_noproc got=%b exp=0", EProc); end
        @(negedge clk);
        ERet = 1'b0; imem_addr = 64'h200; NextPC = 64'h204;
        #1;
        checks++; if (EProc !== 1'b1 || EVAddr !== 64'hF8) begin failures++; $display("FAIL pd_second got=%b/%h exp=1/f8", EProc, EVAddr); end
        @(negedge clk);
        EDataSel = 2'b01;
        #1;
        checks++; if (ExcAck !== 1'b1 || readData !== 64'h3) begin failures++; $display("FAIL pd_esr got=%b/%h exp=1/3", ExcAck, readData); end
    endtask

    task automatic test_eret_idle();
        apply_reset();
        @(negedge clk);
        ERet = 1'b1; ALUBranch = 64'h100;
        #1;
        checks++; if (PCBranch !== 64'h100) begin failures++; $display("FAIL ei_pcb got=%h exp=100", PCBranch); end
        @(negedge clk);
        ERet = 1'b0;
        #1;
        checks++; if (eret_err !== 1'b1 || exc_busy !== 1'b0) begin failures++; $display("FAIL ei_flag got=%b/%b exp=1/0", eret_err, exc_busy); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (eret_err !== 1'b1) begin failures++; $display("FAIL ei_sticky got=%b exp=1", eret_err); end
    endtask

    task automatic test_double_fault();
        apply_reset();
        @(negedge clk);
        exc_req = 4'b0100; imem_addr = 64'h40; NextPC = 64'h44;
        @(negedge clk);
        exc_req = 4'b0001; imem_addr = 64'h300;
        @(negedge clk);
        exc_req = 4'b0; ERet = 1'b1; ALUBranch = 64'h500; EDataSel = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (dbl_fault !== 1'b1 || exc_busy !== 1'b1) begin failures++; $display("FAIL df_flag c=%0d got=%b/%b exp=1/1", c, dbl_fault, exc_busy); end
            checks++; if (EProc !== 1'b1 || EVAddr !== 64'hD8) begin failures++; $display("FAIL df_vec c=%0d got=%b/%h exp=1/d8", c, EProc, EVAddr); end
            checks++; if (PCBranch !== 64'h500 || readData !== 64'h300) begin failures++; $display("FAIL df_regs c=%0d got=%h/%h exp=500/300", c, PCBranch, readData); end
            @(negedge clk);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({dbl_fault, exc_busy, ExcAck} !== 3'b000 || readData !== 64'h0) begin failures++; $display("FAIL df_areset got=%b/%h exp=000/0", {dbl_fault, exc_busy, ExcAck}, readData); end
        reset = 1'b0; ERet = 1'b0;
    endtask

    task automatic test_async_reset_handler();
        apply_reset();
        @(negedge clk);
        exc_req = 4'b0010; imem_addr = 64'h80; NextPC = 64'h84;
        @(negedge clk);
        exc_req = 4'b0; EDataSel = 2'b00;
        #1;
        checks++; if (ExcAck !== 1'b1 || readData !== 64'h84) begin failures++; $display("FAIL ar_pre got=%b/%h exp=1/84", ExcAck, readData); end
        reset = 1'b1;
        #1;
        checks++; if ({exc_busy, ExcAck, dbl_fault} !== 3'b000 || readData !== 64'h0) begin failures++; $display("FAIL ar_handler got=%b/%h exp=000/0", {exc_busy, ExcAck, dbl_fault}, readData); end
        reset = 1'b0;
    endtask

    task automatic test_random();
        int w;
        logic [3:0]  req;
        logic        exp_eproc;
        logic [63:0] exp_vec;
        logic [63:0] exp_pcb;
        logic [63:0] exp_rd;
        for (int seg = 0; seg < 8; seg++) begin
            apply_reset();
            for (int cyc = 0; cyc < 60; cyc++) begin
                @(negedge clk);
                exc_req   = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                             ($urandom_range(0, 5) == 0), ($urandom_range(0, 24) == 0)};
                ERet      = ($urandom_range(0, 3) == 0);
                NextPC    = {$urandom, $urandom};
                imem_addr = {$urandom, $urandom};
                ALUBranch = {$urandom, $urandom};
                EDataSel  = 2'($urandom_range(0, 3));
                #1;
                req = m_pend | exc_req;
                w = -1;
                for (int i = 3; i >= 0; i--) if (req[i]) w = i;
                exp_eproc = (m_state == 2) || (m_state == 0 && w >= 0);
                exp_vec   = (m_state == 2) ? 64'hD8 : 64'hD8 + 64'(w) * 64'h10;
                exp_pcb   = (m_state == 1 && ERet) ? m_elr : ALUBranch;
                case (EDataSel)
                    2'b00:   exp_rd = m_elr;
                    2'b01:   exp_rd = {60'h0, m_esr};
                    2'b10:   exp_rd = m_err;
                    default: exp_rd = 64'h0;
                endcase
                checks++; if (EProc !== exp_eproc) begin failures++; $display("FAIL rnd_eproc s=%0d c=%0d got=%b exp=%b", seg, cyc, EProc, exp_eproc); end
                if (exp_eproc) begin
                    checks++; if (EVAddr !== exp_vec) begin failures++; $display("FAIL rnd_evaddr s=%0d c=%0d got=%h exp=%h", seg, cyc, EVAddr, exp_vec); end
                end
                checks++; if (PCBranch !== exp_pcb) begin failures++; $display("FAIL rnd_pcb s=%0d c=%0d got=%h exp=%h", seg, cyc, PCBranch, exp_pcb); end
                checks++; if (readData !== exp_rd) begin failures++; $display("FAIL rnd_rdata s=%0d c=%0d got=%h exp=%h", seg, cyc, readData, exp_rd); end
                checks++; if ({ExcAck, exc_busy, eret_err, dbl_fault} !== {m_ack, (m_state != 0), m_eerr, m_dbl}) begin
                    failures++; $display("FAIL rnd_status s=%0d c=%0d got=%b exp=%b", seg, cyc,
                        {ExcAck, exc_busy, eret_err, dbl_fault}, {m_ack, (m_state != 0), m_eerr, m_dbl});
                end
                @(posedge clk);
                m_ack = 1'b0;
                if (m_state == 0) begin
                    if (ERet) m_eerr = 1'b1;
                    if (w >= 0) begin
                        m_elr   = MASK[w] ? imem_addr : NextPC;
                        m_esr   = 4'(w + 1);
                        m_err   = imem_addr;
                        m_pend  = req & ~(4'b0001 << w);
                        m_ack   = 1'b1;
                        m_state = 1;
                    end else begin
                        m_pend = req;
                    end
                end else if (m_state == 1) begin
                    m_pend = req;
                    if (ERet) begin
                        m_state = 0;
                    end else if ((exc_req & MASK) != 4'b0) begin
                        m_state = 2;
                        m_dbl   = 1'b1;
                        m_err   = imem_addr;
                    end
                end else begin
                    m_pend = req;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; exc_req = 4'b0; ERet = 1'b0; EDataSel = 2'b00;
        NextPC = 64'h0; imem_addr = 64'h0; ALUBranch = 64'h0;
        test_reset();
        test_vector_basic();
        test_pending();
        test_eret_idle();
        test_double_fault();
        test_async_reset_handler();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
